// File: rtl/trap_ctrl.sv
// trap_ctrl: synchronises, masks and prioritises traps; drives CSR trap inputs, flush and redirect PC (ports: irq lines, MEM exception, CSR feedback in; excepttype/address, flush/new_pc/stall out)
module trap_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_irq_i,
  input  logic            timer_irq_i,
  input  logic            soft_irq_i,
  input  logic            mem_valid_i,
  input  logic [31:0]     mem_excepttype_i,
  input  logic [XLEN-1:0] mem_inst_addr_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic [31:0]     excepttype_o,
  output logic [XLEN-1:0] current_inst_addr_o,
  output logic            flush_o,
  output logic [XLEN-1:0] new_pc_o,
  output logic            stall_req_o
);
  localparam logic [1:0] IDLE = 2'd0, TRAP = 2'd1, SETTLE = 2'd2;
  logic [1:0] state;
  logic [SYNC_STAGES-1:0] s_ext, s_tim, s_sft;
  logic ext_en, sft_en, tim_en, irq_en, exc_ok, take;
  logic [31:0] irq_code, code;
  logic [XLEN-1:0] base, pc;
  logic unused;
  assign unused = ^{mstatus_i[XLEN-1:4], mstatus_i[2:0], mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};
  assign flush_o = state == TRAP;
  assign stall_req_o = state != IDLE;
  always_comb begin
    exc_ok = mem_excepttype_i == 32'd2 || mem_excepttype_i == 32'd8 || mem_excepttype_i == 32'd10;
    ext_en = s_ext[SYNC_STAGES-1] & mie_i[11];
    sft_en = s_sft[SYNC_STAGES-1] & mie_i[3];
    tim_en = s_tim[SYNC_STAGES-1] & mie_i[7];
    irq_en = mstatus_i[3] & (ext_en | sft_en | tim_en);
    irq_code = ext_en ? 32'h8000000B : sft_en ? 32'h80000000 : 32'h80000007;
    code = exc_ok ? mem_excepttype_i : irq_code;
    take = state == IDLE && mem_valid_i && (exc_ok || irq_en);
    base = {mtvec_i[XLEN-1:2], 2'b00};
    pc = mem_excepttype_i == 32'd10 ? mepc_i
       : (!exc_ok && mtvec_i[1:0] == 2'b01) ? base + XLEN'({code[3:0], 2'b00}) : base;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s_ext <= '0;
      s_tim <= '0;
      s_sft <= '0;
      excepttype_o <= '0;
      current_inst_addr_o <= '0;
      new_pc_o <= '0;
    end else begin
      s_ext <= {s_ext[SYNC_STAGES-2:0], ext_irq_i};
      s_tim <= {s_tim[SYNC_STAGES-2:0], timer_irq_i};
      s_sft <= {s_sft[SYNC_STAGES-2:0], soft_irq_i};
      if (take) begin
        state <= TRAP;
        excepttype_o <= code;
        current_inst_addr_o <= mem_inst_addr_i;
        new_pc_o <= pc;
      end else if (state == TRAP) begin
        state <= SETTLE;
        excepttype_o <= '0;
      end else if (state == SETTLE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized checks of trap_ctrl against a rule-level reference model
module tb_trap_ctrl;
  localparam int SS = 2;
  localparam int XLEN = 32;
  logic clk, rst, ext, tim, sft, mem_valid, flush, stall;
  logic [31:0] mem_et, et_o;
  logic [XLEN-1:0] addr, mstatus, mie, mtvec, mepc, cur_addr, new_pc;
  int checks = 0;
  int errors = 0;

  trap_ctrl #(.SYNC_STAGES(SS), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .ext_irq_i(ext), .timer_irq_i(tim), .soft_irq_i(sft),
    .mem_valid_i(mem_valid), .mem_excepttype_i(mem_et), .mem_inst_addr_i(addr),
    .mstatus_i(mstatus), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc),
    .excepttype_o(et_o), .current_inst_addr_o(cur_addr), .flush_o(flush),
    .new_pc_o(new_pc), .stall_req_o(stall)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(output logic [31:0] e, output logic f, output logic [XLEN-1:0] p, output logic [XLEN-1:0] a);
    mem_valid = 1;
    step();
    mem_valid = 0;
    e = et_o;
    f = flush;
    p = new_pc;
    a = cur_addr;
    step(2);
  endtask

  function automatic void model(input logic [31:0] c_in, input logic e, input logic t, input logic s,
                                input logic [XLEN-1:0] ms, input logic [XLEN-1:0] mi,
                                input logic [XLEN-1:0] mt, input logic [XLEN-1:0] mp,
                                output logic tk, output logic [31:0] c, output logic [XLEN-1:0] p);
    logic [31:0] codes [3];
    int en_bit [3];
    logic lvl [3];
    logic [XLEN-1:0] base;
    int k;
    codes = '{32'h8000000B, 32'h80000000, 32'h80000007};
    en_bit = '{11, 3, 7};
    lvl = '{e, s, t};
    base = mt & ~XLEN'(3);
    k = -1;
    for (int i = 2; i >= 0; i--) if (lvl[i] && mi[en_bit[i]]) k = i;
    tk = 0;
    c = 0;
    p = 0;
    if (c_in == 2 || c_in == 8 || c_in == 10) begin
      tk = 1;
      c = c_in;
      p = c_in == 10 ? mp : base;
    end else if (ms[3] && k >= 0) begin
      tk = 1;
      c = codes[k];
      p = mt[1:0] == 2'b01 ? base + 4 * XLEN'(c % 16) : base;
    end
  endfunction

  task automatic test_reset();
    rst = 1;
    step(3);
    checks++; if (et_o !== 0) begin errors++; $display("FAIL reset_et got %h exp 0", et_o); end
    checks++; if (flush !== 0 || stall !== 0) begin errors++; $display("FAIL reset_ctl got %b%b exp 00", flush, stall); end
    checks++; if (new_pc !== 0 || cur_addr !== 0) begin errors++; $display("FAIL reset_pc got %h %h exp 0 0", new_pc, cur_addr); end
    rst = 0;
    step();
  endtask

  task automatic test_ecall();
    mem_et = 8; addr = 32'h100; mtvec = 32'h200; mem_valid = 1;
    step();
    mem_valid = 0; mem_et = 0;
    checks++; if (et_o !== 8 || cur_addr !== 32'h100) begin errors++; $display("FAIL ecall_trap got %h %h exp 8 100", et_o, cur_addr); end
    checks++; if (flush !== 1 || stall !== 1 || new_pc !== 32'h200) begin errors++; $display("FAIL ecall_flush got %b %b %h exp 1 1 200", flush, stall, new_pc); end
    step();
    checks++; if (et_o !== 0 || flush !== 0 || stall !== 1) begin errors++; $display("FAIL ecall_settle got %h %b %b exp 0 0 1", et_o, flush, stall); end
    step();
    checks++; if (et_o !== 0 || flush !== 0 || stall !== 0 || cur_addr !== 32'h100) begin errors++; $display("FAIL ecall_idle got %h %b %b %h exp 0 0 0 100", et_o, flush, stall, cur_addr); end
  endtask

  task automatic test_mret();
    logic [31:0] e; logic f; logic [XLEN-1:0] p, a;
    mem_et = 10; mepc = 32'h344; addr = 32'h500;
    pulse(e, f, p, a);
    mem_et = 0;
    checks++; if (e !== 10 || f !== 1 || p !== 32'h344) begin errors++; $display("FAIL mret got %h %b %h exp a 1 344", e, f, p); end
  endtask

  task automatic test_vec_timer();
    int n;
    mstatus = 8; mie = 32'h80; mtvec = 32'h1001; addr = 32'h80; mem_et = 0; mem_valid = 1;
    tim = 1;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      step();
      if (et_o !== 0) n = i;
    end
    mem_valid = 0; tim = 0;
    checks++; if (n !== SS + 1) begin errors++; $display("FAIL timer_latency got %0d exp %0d", n, SS + 1); end
    checks++; if (et_o !== 32'h80000007 || new_pc !== 32'h101C || cur_addr !== 32'h80) begin errors++; $display("FAIL timer_trap got %h %h %h exp 80000007 101c 80", et_o, new_pc, cur_addr); end
    step(SS + 3);
  endtask

  task automatic test_priority();
    logic [31:0] e; logic f; logic [XLEN-1:0] p, a;
    mstatus = 8; mie = 32'h888; mtvec = 32'h400; ext = 1; sft = 1; tim = 1;
    step(SS);
    pulse(e, f, p, a);
    checks++; if (e !== 32'h8000000B || f !== 1) begin errors++; $display("FAIL prio_ext got %h %b exp 8000000b 1", e, f); end
    mie = 32'h088;
    pulse(e, f, p, a);
    checks++; if (e !== 32'h80000000 || f !== 1) begin errors++; $display("FAIL prio_soft got %h %b exp 80000000 1", e, f); end
    mie = 32'h888; mstatus = 0;
    pulse(e, f, p, a);
    checks++; if (e !== 0 || f !== 0) begin errors++; $display("FAIL prio_masked got %h %b exp 0 0", e, f); end
    ext = 0; sft = 0; tim = 0;
    step(SS);
  endtask

  task automatic test_simul_exc();
    for (int v = 0; v < 2; v++) begin
      mstatus = 8; mie = 32'h800; ext = 1; mem_et = 0;
      step(SS);
      mem_et = 2; mem_valid = 1;
      step();
      mem_et = 0;
      if (v == 1) mstatus = 0;
      checks++; if (et_o !== 2 || flush !== 1) begin errors++; $display("FAIL simul_exc%0d got %h %b exp 2 1", v, et_o, flush); end
      step();
      checks++; if (et_o !== 0 || flush !== 0 || stall !== 1) begin errors++; $display("FAIL simul_settle%0d got %h %b %b exp 0 0 1", v, et_o, flush, stall); end
      step();
      checks++; if (flush !== 0 || stall !== 0) begin errors++; $display("FAIL simul_idle%0d got %b %b exp 0 0", v, flush, stall); end
      step();
      checks++; if (et_o !== (v == 0 ? 32'h8000000B : 32'h0) || flush !== (v == 0)) begin errors++; $display("FAIL simul_irq%0d got %h %b", v, et_o, flush); end
      mem_valid = 0; ext = 0;
      step(SS + 2);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    mstatus = 8; mie = 32'h800; ext = 1; mem_et = 0;
    step(SS);
    mem_valid = 1;
    step();
    checks++; if (flush !== 1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", flush); end
    rst = 1;
    step();
    rst = 0;
    checks++; if (flush !== 0 || stall !== 0 || et_o !== 0) begin errors++; $display("FAIL rstmid got %b %b %h exp 0 0 0", flush, stall, et_o); end
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      step();
      if (flush === 1) n = i;
    end
    checks++; if (n !== SS + 1) begin errors++; $display("FAIL rstmid_refill got %0d exp %0d", n, SS + 1); end
    mem_valid = 0; ext = 0;
    step(SS + 3);
  endtask

  task automatic test_random();
    logic [31:0] e, xc; logic f, tk; logic [XLEN-1:0] p, a, xp;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: mem_et = 0;
        1: mem_et = 2;
        2: mem_et = 8;
        3: mem_et = 10;
        default: mem_et = $urandom;
      endcase
      ext = 1'($urandom); tim = 1'($urandom); sft = 1'($urandom);
      mstatus = $urandom_range(0, 3) != 0 ? 32'h8 : 32'h0;
      mie = $urandom & 32'h888;
      mtvec = $urandom; mepc = $urandom; addr = $urandom;
      step(SS);
      model(mem_et, ext, tim, sft, mstatus, mie, mtvec, mepc, tk, xc, xp);
      pulse(e, f, p, a);
      if (tk) begin
        checks++; if (e !== xc || f !== 1) begin errors++; $display("FAIL rand%0d_code got %h %b exp %h 1", it, e, f, xc); end
        checks++; if (p !== xp || a !== addr) begin errors++; $display("FAIL rand%0d_pc got %h %h exp %h %h", it, p, a, xp, addr); end
      end else begin
        checks++; if (e !== 0 || f !== 0) begin errors++; $display("FAIL rand%0d_none got %h %b exp 0 0", it, e, f); end
      end
    end
    ext = 0; tim = 0; sft = 0; mem_et = 0;
  endtask

  initial begin
    rst = 1; ext = 0; tim = 0; sft = 0; mem_valid = 0; mem_et = 0;
    addr = 0; mstatus = 0; mie = 0; mtvec = 0; mepc = 0;
    test_reset();
    test_ecall();
    test_mret();
    test_vec_timer();
    test_priority();
    test_simul_exc();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap arbitration stage directly upstream of the CSR file.
- Collects synchronous exceptions from the MEM stage and three asynchronous interrupt lines; synchronises, masks and prioritises them.
- Drives the CSR trap inputs (excepttype, faulting/retiring instruction address).
- Issues pipeline flush plus redirect PC (trap vector or mepc) to the PC/ctrl logic.
- Consumes mstatus/mie/mtvec/mepc back from the CSR file.

Parameters:
SYNC_STAGES, 2, number of flops in each interrupt-line synchroniser (min 2).
XLEN, 32, data/address width.

Ports:
clk  in  1  clock
rst  in  1  reset
ext_irq_i  in  1  external interrupt request, async level
timer_irq_i  in  1  timer interrupt request, async level
soft_irq_i  in  1  software interrupt request, async level
mem_valid_i  in  1  an instruction is present in MEM this cycle
mem_excepttype_i  in  32  MEM-stage exception code: 0 none, 2 illegal, 8 ecall, 10 mret
mem_inst_addr_i  in  XLEN  PC of the MEM-stage instruction
mstatus_i  in  XLEN  from CSR; bit 3 = MIE
mie_i  in  XLEN  from CSR; bits 11/7/3 = MEIE/MTIE/MSIE
mtvec_i  in  XLEN  from CSR; [1:0] mode, [31:2] base
mepc_i  in  XLEN  from CSR
excepttype_o  out  32  trap code to CSR; 0 = none
current_inst_addr_o  out  XLEN  instruction address to CSR
flush_o  out  1  flush all pipeline stages
new_pc_o  out  XLEN  redirect target, valid while flush_o=1
stall_req_o  out  1  hold fetch/decode while a trap is in progress

Behaviour:
- Reset (clk, rst synchronous, active-high):
  - state=IDLE; all outputs 0; all synchroniser flops 0.
  - rst mid-trap aborts to IDLE with outputs 0 on the next edge.
- Synchronisers: each irq line passes through SYNC_STAGES flops; only the last stage is used.
- Interrupt enable: irq_en = mstatus_i[3] & (sync_ext&mie_i[11] | sync_soft&mie_i[3] | sync_timer&mie_i[7]).
- Interrupt priority: ext > soft > timer.
- Interrupt codes (excepttype_o): ext 32'h8000000B, soft 32'h80000000, timer 32'h80000007.
- Event selection in IDLE (evaluated only when mem_valid_i=1):
  - A recognised exception code (2, 8 or 10) wins over any interrupt and is passed through unchanged.
  - Otherwise an enabled interrupt is taken.
  - Any other mem_excepttype_i value is treated as none.
  - mem_valid_i=0: nothing is taken; interrupts remain pending (level, not latched).
- new_pc rule:
  - mret: mepc_i.
  - Exception, or mtvec mode 0: {mtvec_i[31:2],2'b00}.
  - Interrupt with mtvec mode 1: {mtvec_i[31:2],2'b00} + 4*code[3:0].
  - Modes 2/3 are treated as 0.
  - Arithmetic is XLEN bits, wrap ignored.
- FSM IDLE -> TRAP -> SETTLE -> IDLE:
  - IDLE, event at cycle N: on edge N, register excepttype_o, current_inst_addr_o=mem_inst_addr_i and new_pc_o.
  - TRAP, cycle N+1 (exactly one cycle): excepttype_o/current_inst_addr_o held; flush_o=1; stall_req_o=1. The CSR file updates at edge N+1.
  - SETTLE, cycle N+2: excepttype_o=0, flush_o=0, stall_req_o=1. All inputs are ignored so the updated mstatus (MIE=0) propagates back.
  - Cycle N+3: IDLE, new events accepted.
- Outputs in IDLE: excepttype_o=0, flush_o=0, stall_req_o=0; current_inst_addr_o/new_pc_o keep their last values.
- Latency from event to flush is exactly 1 cycle. Back-to-back traps are spaced at least 3 cycles apart.
- An interrupt asserted during TRAP/SETTLE is taken in IDLE only if still level-high and still enabled by the updated mstatus/mie.

Test Plan:
- Ecall: mem_valid_i=1, mem_excepttype_i=8, addr 32'h100, mtvec=32'h200 -> next cycle excepttype_o=8, current_inst_addr_o=32'h100, flush_o=1, new_pc_o=32'h200; SETTLE one cycle with stall_req_o=1; then IDLE.
- Mret: mem_excepttype_i=10, mepc_i=32'h344 -> flush_o=1 with new_pc_o=32'h344, excepttype_o=10.
- Vectored timer: MIE=1, mie[7]=1, mtvec=32'h1001, timer_irq_i high, addr 32'h80 -> excepttype_o=32'h80000007 exactly SYNC_STAGES+1 cycles after assertion; new_pc_o=32'h101C; current_inst_addr_o=32'h80.
- Priority/masking:
  - ext+soft+timer high with all enabled -> 32'h8000000B.
  - Same with mie[11]=0 -> 32'h80000000.
  - mstatus[3]=0 -> no trap, flush_o stays 0.
- Simultaneous exception: illegal (code 2) in MEM with ext irq enabled -> excepttype_o=2. The interrupt is taken after SETTLE if still enabled; with mstatus[3] returned as 0 it is not taken.
- Reset mid-trap: assert rst during TRAP -> next edge flush_o=0, stall_req_o=0, excepttype_o=0; a pending irq is re-recognised only after the synchroniser refills.
